// File: rtl/isolde_exec_dispatcher_if.sv
// isolde_exec_dispatcher_if: decoder and exec-unit handshake bundle for the dispatcher
// master: dispatcher side (takes dec_* requests, drives unit_* requests and operands)
// slave : environment side (decoder plus exec units)
// dec_*  : req/gnt/dne decoder handshake, illegal flag, unit select, instr, imm32 operands
// unit_* : one-hot req, per-unit gnt/dne, per-unit active-low reset, latched operands
interface isolde_exec_dispatcher_if #(
   parameter int IMM32_OPS = 4,
   parameter int N_UNITS   = 2
);
   logic                      dec_req_i;
   logic                      dec_gnt_o;
   logic                      dec_dne_o;
   logic                      dec_illegal_i;
   logic [2:0]                dec_unit_sel_i;
   logic [31:0]               dec_instr_i;
   logic [IMM32_OPS*32-1:0]   dec_imm32_i;
   logic [IMM32_OPS-1:0]      dec_imm32_valid_i;
   logic [N_UNITS-1:0]        unit_req_o;
   logic [N_UNITS-1:0]        unit_gnt_i;
   logic [N_UNITS-1:0]        unit_dne_i;
   logic [N_UNITS-1:0]        unit_rst_no;
   logic [31:0]               unit_instr_o;
   logic [IMM32_OPS*32-1:0]   unit_imm32_o;
   logic [IMM32_OPS-1:0]      unit_imm32_valid_o;
   modport master (
      input  dec_req_i, dec_illegal_i, dec_unit_sel_i, dec_instr_i, dec_imm32_i, dec_imm32_valid_i,
             unit_gnt_i, unit_dne_i,
      output dec_gnt_o, dec_dne_o, unit_req_o, unit_rst_no, unit_instr_o, unit_imm32_o,
             unit_imm32_valid_o
   );
   modport slave (
      output dec_req_i, dec_illegal_i, dec_unit_sel_i, dec_instr_i, dec_imm32_i, dec_imm32_valid_i,
             unit_gnt_i, unit_dne_i,
      input  dec_gnt_o, dec_dne_o, unit_req_o, unit_rst_no, unit_instr_o, unit_imm32_o,
             unit_imm32_valid_o
   );
endinterface

// File: rtl/isolde_exec_dispatcher.sv
// isolde_exec_dispatcher: routes one decoded custom instruction at a time to an exec unit
// clk_i, rst_ni : clock, asynchronous active-low reset
// bus           : decoder and exec-unit handshakes (isolde_exec_dispatcher_if.master)
// busy_o        : high whenever not idle
// err_o         : one-cycle pulse with dec_dne_o when the instruction failed
// timeout_o     : sticky watchdog-expiry flag, cleared only by reset
module isolde_exec_dispatcher #(
   parameter int IMM32_OPS      = 4,
   parameter int N_UNITS        = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int RST_CYCLES     = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   isolde_exec_dispatcher_if.master  bus,
   output logic                      busy_o,
   output logic                      err_o,
   output logic                      timeout_o
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DNE, RECOVER, DONE} state_t;
   localparam int MAXC = TIMEOUT_CYCLES > RST_CYCLES ? TIMEOUT_CYCLES : RST_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   state_t                  state, next;
   logic [CW-1:0]           cnt;
   logic [2:0]              sel;
   logic                    err_q;
   logic [N_UNITS-1:0]      sel_oh;
   logic                    hit_gnt, hit_dne, expire, bad, take;
   logic [31:0]             instr_q;
   logic [IMM32_OPS*32-1:0] imm_q;
   logic [IMM32_OPS-1:0]    val_q;
   // sel_oh is zero for out-of-range selects, so foreign units never see traffic
   assign sel_oh  = N_UNITS'(1) << sel;
   assign hit_gnt = |(bus.unit_gnt_i & sel_oh);
   assign hit_dne = |(bus.unit_dne_i & sel_oh);
   assign expire  = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
   assign bad     = bus.dec_illegal_i || int'(bus.dec_unit_sel_i) >= N_UNITS;
   assign take    = state == IDLE && bus.dec_req_i;
   always_comb begin
      next = state;
      case (state)
         IDLE:     next = bus.dec_req_i ? (bad ? DONE : ISSUE) : IDLE;
         // watchdog beats a late grant; in WAIT_DNE a final-cycle done beats the watchdog
         ISSUE:    next = expire ? RECOVER : hit_gnt ? WAIT_DNE : ISSUE;
         WAIT_DNE: next = hit_dne ? DONE : expire ? RECOVER : WAIT_DNE;
         RECOVER:  next = cnt == CW'(RST_CYCLES - 1) ? DONE : RECOVER;
         default:  next = IDLE;
      endcase
      bus.dec_gnt_o          = rst_ni && take;
      bus.dec_dne_o          = state == DONE;
      bus.unit_req_o         = state == ISSUE ? sel_oh : '0;
      bus.unit_rst_no        = {N_UNITS{rst_ni}} & ~(state == RECOVER ? sel_oh : '0);
      bus.unit_instr_o       = instr_q;
      bus.unit_imm32_o       = imm_q;
      bus.unit_imm32_valid_o = val_q;
      busy_o                 = state != IDLE;
      err_o                  = state == DONE && err_q;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= IDLE;
         cnt       <= '0;
         sel       <= '0;
         err_q     <= 1'b0;
         timeout_o <= 1'b0;
         instr_q   <= '0;
         imm_q     <= '0;
         val_q     <= '0;
      end else begin
         state <= next;
         // one counter serves both the watchdog window and the reset pulse length
         cnt   <= (next != state && (next == ISSUE || next == RECOVER)) ? '0 : cnt + 1'b1;
         if (take) begin
            sel     <= bus.dec_unit_sel_i;
            instr_q <= bus.dec_instr_i;
            imm_q   <= bus.dec_imm32_i;
            val_q   <= bus.dec_imm32_valid_i;
         end
         err_q     <= state == DONE ? 1'b0 : err_q || (take && bad) || (state != RECOVER && next == RECOVER);
         timeout_o <= timeout_o || (state != RECOVER && next == RECOVER);
      end
   end
endmodule

// File: tb/tb_isolde_exec_dispatcher.sv
// tb_isolde_exec_dispatcher: directed and randomized checks of the exec dispatcher
module tb_isolde_exec_dispatcher;
   localparam int N = 2, IMM = 4, T = 8, R = 4;
   logic clk = 1'b0, rst_n = 1'b1, busy, err, tmo;
   int checks = 0, fails = 0;
   logic sticky = 1'b0;
   logic [31:0] l_instr = '0;
   logic [IMM*32-1:0] l_imm = '0;
   logic [IMM-1:0] l_val = '0;
   always #5 clk = ~clk;
   isolde_exec_dispatcher_if #(.IMM32_OPS(IMM), .N_UNITS(N)) bus ();
   isolde_exec_dispatcher #(.IMM32_OPS(IMM), .N_UNITS(N), .TIMEOUT_CYCLES(T), .RST_CYCLES(R)) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus), .busy_o(busy), .err_o(err), .timeout_o(tmo)
   );
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [IMM*32-1:0] rimm();
      logic [IMM*32-1:0] r;
      for (int i = 0; i < IMM; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction
   task automatic chk_reset();
      chk("rst_gnt", bus.dec_gnt_o, 0);
      chk("rst_dne", bus.dec_dne_o, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", tmo, 0);
      chk("rst_req", bus.unit_req_o, 0);
      chk("rst_unit_rst_n", bus.unit_rst_no, 0);
      chk("rst_instr", bus.unit_instr_o, 0);
      chk("rst_imm", bus.unit_imm32_o, 0);
      chk("rst_valid", bus.unit_imm32_valid_o, 0);
   endtask
   task automatic idle_cycle();
      logic [N-1:0] all1 = '1;
      @(negedge clk);
      bus.dec_req_i = 1'b0;
      bus.dec_illegal_i = 1'($urandom);
      bus.dec_unit_sel_i = 3'($urandom);
      bus.dec_instr_i = $urandom;
      bus.dec_imm32_i = rimm();
      bus.dec_imm32_valid_i = IMM'($urandom);
      bus.unit_gnt_i = N'($urandom);
      bus.unit_dne_i = N'($urandom);
      #1;
      chk("idle_gnt", bus.dec_gnt_o, 0);
      chk("idle_busy", busy, 0);
      chk("idle_dne", bus.dec_dne_o, 0);
      chk("idle_req", bus.unit_req_o, 0);
      chk("idle_unit_rst_n", bus.unit_rst_no, all1);
      chk("idle_timeout", tmo, sticky);
      chk("idle_instr", bus.unit_instr_o, l_instr);
   endtask
   // g: cycles the unit waits after the first request before granting
   // w: cycles after entering WAIT_DNE before done (<0: never); abort_t: cycle to reset at (<0: none)
   task automatic run_txn(input logic [2:0] sel, input logic ill, input int g, input int w,
                          input logic [31:0] instr, input logic [IMM*32-1:0] imm,
                          input logic [IMM-1:0] val, input int abort_t);
      logic [N-1:0] oh = N'(1) << sel;
      logic [N-1:0] all1 = '1;
      logic [N-1:0] e_req, e_rst;
      bit inv = ill || sel >= N;
      bit to;
      int done_t, req_end;
      // unit window is T cycles counted from the first request cycle (t=1)
      if (inv) begin to = 0; done_t = 1; end
      else if (w >= 0 && g + w + 2 <= T) begin to = 0; done_t = g + w + 3; end
      else begin to = 1; done_t = T + R + 1; end
      req_end = inv ? 0 : (g + 1 < T ? g + 1 : T);
      for (int t = 0; t <= done_t; t++) begin
         @(negedge clk);
         bus.dec_req_i = t == 0 ? 1'b1 : 1'($urandom);
         bus.dec_illegal_i = t == 0 ? ill : 1'($urandom);
         bus.dec_unit_sel_i = t == 0 ? sel : 3'($urandom);
         bus.dec_instr_i = t == 0 ? instr : $urandom;
         bus.dec_imm32_i = t == 0 ? imm : rimm();
         bus.dec_imm32_valid_i = t == 0 ? val : IMM'($urandom);
         bus.unit_gnt_i = (N'($urandom) & ~oh) | ((!inv && t == g + 1) ? oh : '0);
         bus.unit_dne_i = (N'($urandom) & ~oh) |
                          (((!inv && w >= 0 && t == g + w + 2) || (t >= 1 && t <= g + 1 && $urandom_range(0, 1) == 1)) ? oh : '0);
         #1;
         e_req = (t >= 1 && t <= req_end) ? oh : '0;
         e_rst = (to && t > T && t <= T + R) ? ~oh : all1;
         chk("dec_gnt", bus.dec_gnt_o, t == 0);
         chk("busy", busy, t != 0);
         chk("dec_dne", bus.dec_dne_o, t == done_t);
         chk("err", err, t == done_t && (inv || to));
         chk("unit_req", bus.unit_req_o, e_req);
         chk("unit_rst_n", bus.unit_rst_no, e_rst);
         chk("timeout", tmo, sticky || (to && t > T));
         chk("unit_instr", bus.unit_instr_o, t == 0 ? l_instr : instr);
         chk("unit_imm", bus.unit_imm32_o, t == 0 ? l_imm : imm);
         chk("unit_valid", bus.unit_imm32_valid_o, t == 0 ? l_val : val);
         if (t == abort_t) begin
            #2;
            bus.dec_req_i = 1'b1;
            rst_n = 1'b0;
            #1;
            chk_reset();
            sticky = 1'b0;
            l_instr = '0;
            l_imm = '0;
            l_val = '0;
            bus.dec_req_i = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
      end
      if (to) sticky = 1'b1;
      l_instr = instr;
      l_imm = imm;
      l_val = val;
   endtask
   initial begin
      bus.dec_req_i = 1'b1;
      bus.dec_illegal_i = 1'b0;
      bus.dec_unit_sel_i = '0;
      bus.dec_instr_i = '0;
      bus.dec_imm32_i = '0;
      bus.dec_imm32_valid_i = '0;
      bus.unit_gnt_i = '0;
      bus.unit_dne_i = '0;
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk_reset();
      bus.dec_req_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycle();
      idle_cycle();
      run_txn(3'd1, 1'b0, 0, 1, 32'h0000_700B, rimm(), 4'b0011, -1);
      run_txn(3'd1, 1'b1, 0, 0, $urandom, rimm(), 4'b1111, -1);
      run_txn(3'd5, 1'b0, 0, 0, $urandom, rimm(), 4'b0101, -1);
      idle_cycle();
      run_txn(3'd0, 1'b0, 0, -1, $urandom, rimm(), 4'b1000, -1);
      run_txn(3'd0, 1'b0, 1, 3, $urandom, rimm(), 4'b0001, -1);
      run_txn(3'd1, 1'b0, 0, 6, $urandom, rimm(), 4'b0110, -1);
      run_txn(3'd0, 1'b0, 2, 4, $urandom, rimm(), 4'b1001, -1);
      run_txn(3'd1, 1'b0, 0, 7, $urandom, rimm(), 4'b1110, -1);
      run_txn(3'd0, 1'b0, 7, 0, $urandom, rimm(), 4'b0010, -1);
      run_txn(3'd1, 1'b0, 8, 0, $urandom, rimm(), 4'b0100, -1);
      for (int k = 0; k < 40; k++) begin
         int gap = $urandom_range(0, 2);
         for (int j = 0; j < gap; j++) idle_cycle();
         run_txn($urandom_range(0, 7) == 0 ? 3'($urandom) : 3'($urandom_range(0, N - 1)),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0 ? 9 : $urandom_range(0, 3),
                 $urandom_range(0, 5) == 0 ? -1 : $urandom_range(0, 7),
                 $urandom, rimm(), IMM'($urandom), -1);
      end
      run_txn(3'd0, 1'b0, 0, -1, $urandom, rimm(), 4'b1111, 3);
      for (int j = 0; j < 3; j++) idle_cycle();
      for (int k = 0; k < 6; k++)
         run_txn(3'($urandom_range(0, N - 1)), 1'b0, $urandom_range(0, 3),
                 $urandom_range(0, 4) == 0 ? -1 : $urandom_range(0, 7),
                 $urandom, rimm(), IMM'($urandom), -1);
      idle_cycle();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
